// File: rtl/moving_average_filter_pkg.sv
// Shared constants for the boxcar averager: rounding-mode codes and the
// default-configuration window/sum sizes.
package moving_average_filter_pkg;
   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_LOG2_WIN = 3;
   localparam int WIN          = 1 << DEF_LOG2_WIN;
   localparam int SUM_W        = DEF_DATA_W + DEF_LOG2_WIN;
endpackage

// File: rtl/moving_average_filter_ring_buffer.sv
// Circular sample store for the averager. Returns the entry about to be
// overwritten (the oldest sample) combinationally; zeroed synchronously.
module ma_ring_buffer
   import moving_average_filter_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int LOG2_WIN = DEF_LOG2_WIN
) (
   input  logic              clk,
   input  logic              i_zero,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_oldest
);
   localparam int WIN = 1 << LOG2_WIN;

   logic [DATA_W-1:0]   r_buf [WIN];
   logic [LOG2_WIN-1:0] r_wptr;

   assign o_oldest = r_buf[r_wptr];

   // Pointer width equals log2 of the window, so increment wraps by itself.
   always_ff @(posedge clk) begin
      if (i_zero) begin
         r_wptr <= '0;
         for (int i = 0; i < WIN; i++) r_buf[i] <= '0;
      end else if (i_wr_en) begin
         r_buf[r_wptr] <= i_wdata;
         r_wptr        <= r_wptr + 1'b1;
      end
   end
endmodule

// File: rtl/moving_average_filter.sv
// Streaming moving-average filter over the last 2^LOG2_WIN accepted samples,
// using a running sum (one add, one subtract per sample) and 1-cycle latency.
module moving_average_filter
   import moving_average_filter_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LOG2_WIN   = DEF_LOG2_WIN,
   parameter int ROUND_MODE = ROUND_HALF_UP
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   data,
   input  logic                clear,
   output logic                valid,
   output logic [DATA_W-1:0]   out,
   output logic [LOG2_WIN:0]   fill
);
   localparam int WIN   = 1 << LOG2_WIN;
   localparam int SUM_W = DATA_W + LOG2_WIN;
   localparam logic [SUM_W:0]    RND      = (ROUND_MODE == ROUND_HALF_UP) ?
                                             (SUM_W+1)'(WIN / 2) : '0;
   localparam logic [LOG2_WIN:0] FILL_MAX = (LOG2_WIN+1)'(WIN);

   logic [SUM_W-1:0]  r_sum;
   logic [LOG2_WIN:0] r_fill;
   logic              r_valid;
   logic [DATA_W-1:0] r_out;

   logic              w_zero;
   logic              w_accept;
   logic [DATA_W-1:0] w_oldest;
   logic [SUM_W-1:0]  w_sum_next;
   logic [LOG2_WIN:0] w_fill_next;

   // The extra adder bit keeps sum + R from wrapping before the shift.
   function automatic logic [DATA_W-1:0] f_avg(input logic [SUM_W-1:0] s);
      logic [SUM_W:0] t;
      t = {1'b0, s} + RND;
      return DATA_W'(t >> LOG2_WIN);
   endfunction

   assign w_zero      = reset | clear;
   assign w_accept    = in_valid & ~w_zero;
   assign w_sum_next  = r_sum + SUM_W'(data) - SUM_W'(w_oldest);
   assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

   ma_ring_buffer #(
      .DATA_W   (DATA_W),
      .LOG2_WIN (LOG2_WIN)
   ) u_ring (
      .clk      (clk),
      .i_zero   (w_zero),
      .i_wr_en  (w_accept),
      .i_wdata  (data),
      .o_oldest (w_oldest)
   );

   always_ff @(posedge clk) begin
      if (w_zero) begin
         r_sum   <= '0;
         r_fill  <= '0;
         r_valid <= 1'b0;
         r_out   <= '0;
      end else if (w_accept) begin
         r_sum  <= w_sum_next;
         r_fill <= w_fill_next;
         if (w_fill_next == FILL_MAX) begin
            r_out   <= f_avg(w_sum_next);
            r_valid <= 1'b1;
         end else begin
            r_valid <= 1'b0;
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign valid = r_valid;
   assign out   = r_out;
   assign fill  = r_fill;
endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: a queue-based window model checked
// every cycle against a round-half-up and a truncating instance.
module tb_moving_average_filter;
   localparam int DATA_W   = 8;
   localparam int LOG2_WIN = 3;
   localparam int WIN      = 1 << LOG2_WIN;

   logic              clk = 1'b0;
   logic              reset, in_valid, clear;
   logic [DATA_W-1:0] data;
   logic              valid_r, valid_t;
   logic [DATA_W-1:0] out_r, out_t;
   logic [LOG2_WIN:0] fill_r, fill_t;

   int n_checks = 0;
   int n_errors = 0;

   int q[$];
   int m_valid = 0, m_out_r = 0, m_out_t = 0;

   always #5 clk = ~clk;

   moving_average_filter #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN), .ROUND_MODE(1)) dut_r (
      .clk(clk), .reset(reset), .in_valid(in_valid), .data(data), .clear(clear),
      .valid(valid_r), .out(out_r), .fill(fill_r));

   moving_average_filter #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN), .ROUND_MODE(0)) dut_t (
      .clk(clk), .reset(reset), .in_valid(in_valid), .data(data), .clear(clear),
      .valid(valid_t), .out(out_t), .fill(fill_t));

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, advance the window model, then compare both instances.
   task automatic step(input logic v, input int d, input logic c, input logic r);
      int s;
      in_valid = v; data = DATA_W'(d); clear = c; reset = r;
      if (r || c) begin
         q.delete();
         m_valid = 0; m_out_r = 0; m_out_t = 0;
      end else if (v) begin
         q.push_back(d);
         if (q.size() > WIN) void'(q.pop_front());
         if (q.size() == WIN) begin
            s = 0;
            foreach (q[i]) s += q[i];
            m_out_r = (s + WIN / 2) / WIN;
            m_out_t = s / WIN;
            m_valid = 1;
         end else begin
            m_valid = 0;
         end
      end else begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      chk("valid_r", int'(valid_r), m_valid);
      chk("out_r",   int'(out_r),   m_out_r);
      chk("fill_r",  int'(fill_r),  q.size());
      chk("valid_t", int'(valid_t), m_valid);
      chk("out_t",   int'(out_t),   m_out_t);
      chk("fill_t",  int'(fill_t),  q.size());
   endtask

   task automatic do_clear();
      step(1'b0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; clear = 1'b0; data = '0;

      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 77, 1'b0, 1'b1);
      chk("rst_fill", int'(fill_r), 0);
      chk("rst_out",  int'(out_r), 0);
      chk("rst_valid", int'(valid_r), 0);

      // Eight accepts of 100
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 100, 1'b0, 1'b0);
         if (i < 7) chk("fill100_valid", int'(valid_r), 0);
      end
      chk("avg100_valid", int'(valid_r), 1);
      chk("avg100_out",   int'(out_r), 100);
      chk("avg100_fill",  int'(fill_r), 8);
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("idle_hold_out", int'(out_r), 100);
      chk("idle_valid", int'(valid_r), 0);

      // Ramp 0,10,...,150
      do_clear();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i * 10, 1'b0, 1'b0);
         if (i >= 7) chk("ramp_out", int'(out_r), 35 + (i - 7) * 10);
      end

      // Rounding: sum 4 then sum 3
      do_clear();
      for (int i = 0; i < 7; i++) step(1'b1, 0, 1'b0, 1'b0);
      step(1'b1, 4, 1'b0, 1'b0);
      chk("sum4_round", int'(out_r), 1);
      chk("sum4_trunc", int'(out_t), 0);
      do_clear();
      for (int i = 0; i < 7; i++) step(1'b1, 0, 1'b0, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      chk("sum3_round", int'(out_r), 0);
      chk("sum3_trunc", int'(out_t), 0);

      // Full-scale samples
      do_clear();
      for (int i = 0; i < 8; i++) step(1'b1, 255, 1'b0, 1'b0);
      chk("max_round", int'(out_r), 255);
      chk("max_trunc", int'(out_t), 255);
      step(1'b1, 0, 1'b0, 1'b0);
      chk("max_then0_round", int'(out_r), 223);
      chk("max_then0_trunc", int'(out_t), 223);

      // Gapped qualifier, constant 50
      do_clear();
      for (int i = 0; i < 60; i++) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         step(v, 50, 1'b0, 1'b0);
         if (!v) chk("gap_idle_valid", int'(valid_r), 0);
         if (valid_r) chk("gap_out", int'(out_r), 50);
      end

      // clear with in_valid from steady state
      for (int i = 0; i < 8; i++) step(1'b1, 200, 1'b0, 1'b0);
      step(1'b1, 99, 1'b1, 1'b0);
      chk("clr_fill", int'(fill_r), 0);
      chk("clr_valid", int'(valid_r), 0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 20, 1'b0, 1'b0);
         if (i < 7) chk("clr_refill_valid", int'(valid_r), 0);
      end
      chk("clr_out", int'(out_r), 20);
      chk("clr_valid8", int'(valid_r), 1);

      // reset with in_valid mid-stream
      for (int i = 0; i < 5; i++) step(1'b1, 240, 1'b0, 1'b0);
      step(1'b1, 99, 1'b0, 1'b1);
      chk("rst_mid_fill", int'(fill_r), 0);
      chk("rst_mid_out", int'(out_r), 0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 20, 1'b0, 1'b0);
         if (i < 7) chk("rst_refill_valid", int'(valid_r), 0);
      end
      chk("rst_out20", int'(out_r), 20);
      chk("rst_valid8", int'(valid_r), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
